// File: rtl/rob_commit.sv
// Reorder buffer with in-order retirement.
// Decode allocates at the tail, the CDB marks entries done by tag, and the
// head entry retires to the register file once it is done (one per cycle).
module rob_commit #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [OP_W-1:0]   alloc_opcode,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_value,
  output logic              wb_err,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [REG_W-1:0]  commit_reg,
  output logic [DATA_W-1:0] commit_value,
  output logic [OP_W-1:0]   commit_opcode,
  output logic [TAG_W:0]    count,
  output logic              empty,
  output logic              full
);

  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

  // Per-entry status flags (reset) and payload (not reset).
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [OP_W-1:0]   opcode_mem [DEPTH];
  logic [REG_W-1:0]  dest_mem   [DEPTH];
  logic [DATA_W-1:0] value_mem  [DEPTH];

  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;

  logic              commit_valid_q;
  logic [TAG_W-1:0]  commit_tag_q;
  logic [REG_W-1:0]  commit_reg_q;
  logic [DATA_W-1:0] commit_value_q;
  logic [OP_W-1:0]   commit_opcode_q;
  logic              wb_err_q;

  logic              alloc_fire;
  logic              wb_legal;
  logic              commit_fire;

  // Handshake decisions, all taken from pre-edge state.
  assign alloc_ready = (count_q < DEPTH_C);
  assign alloc_tag   = tail_q;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign wb_legal    = wb_valid & busy_q[wb_tag] & ~done_q[wb_tag];
  assign commit_fire = busy_q[head_q] & done_q[head_q];

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  assign commit_valid  = commit_valid_q;
  assign commit_tag    = commit_tag_q;
  assign commit_reg    = commit_reg_q;
  assign commit_value  = commit_value_q;
  assign commit_opcode = commit_opcode_q;
  assign wb_err        = wb_err_q;

  // Next-state for pointers, occupancy and per-entry flags.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = done_q;

    if (commit_fire) begin
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      head_d         = head_q + TAG_W'(1);
    end
    // Alloc never targets the head on a commit edge: tail == head only when
    // empty (no commit) or full (no alloc).
    if (alloc_fire) begin
      busy_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      tail_d         = tail_q + TAG_W'(1);
    end
    // A legal writeback targets a busy, not-done entry, which is neither the
    // committing head nor the freshly allocated tail.
    if (wb_legal) begin
      done_d[wb_tag] = 1'b1;
    end

    unique case ({alloc_fire, commit_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers, occupancy, entry flags.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Entry payload storage.
  // NOTE: payload arrays are not reset; busy/done gate every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      opcode_mem[tail_q] <= alloc_opcode;
      dest_mem[tail_q]   <= alloc_dest;
    end
    if (wb_legal) begin
      value_mem[wb_tag] <= wb_value;
    end
  end

  // Registered commit port and writeback error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid_q  <= 1'b0;
      commit_tag_q    <= '0;
      commit_reg_q    <= '0;
      commit_value_q  <= '0;
      commit_opcode_q <= '0;
      wb_err_q        <= 1'b0;
    end else begin
      commit_valid_q <= commit_fire;
      if (commit_fire) begin
        commit_tag_q    <= head_q;
        commit_reg_q    <= dest_mem[head_q];
        commit_value_q  <= value_mem[head_q];
        commit_opcode_q <= opcode_mem[head_q];
      end
      wb_err_q <= wb_valid & ~wb_legal;
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed scenarios followed by random
// traffic, compared each cycle against an in-order queue model of the ROB.
module tb_rob_commit;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic [3:0]  alloc_opcode;
  logic [3:0]  alloc_dest;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        wb_valid;
  logic [2:0]  wb_tag;
  logic [15:0] wb_value;
  logic        wb_err;
  logic        commit_valid;
  logic [2:0]  commit_tag;
  logic [3:0]  commit_reg;
  logic [15:0] commit_value;
  logic [3:0]  commit_opcode;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  rob_commit dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid   (alloc_valid),
    .alloc_opcode  (alloc_opcode),
    .alloc_dest    (alloc_dest),
    .alloc_ready   (alloc_ready),
    .alloc_tag     (alloc_tag),
    .wb_valid      (wb_valid),
    .wb_tag        (wb_tag),
    .wb_value      (wb_value),
    .wb_err        (wb_err),
    .commit_valid  (commit_valid),
    .commit_tag    (commit_tag),
    .commit_reg    (commit_reg),
    .commit_value  (commit_value),
    .commit_opcode (commit_opcode),
    .count         (count),
    .empty         (empty),
    .full          (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: in-flight instructions in program order.
  typedef struct {
    logic [2:0]  tag;
    logic [3:0]  op;
    logic [3:0]  dest;
    bit          done;
    logic [15:0] val;
  } ent_t;

  ent_t        q[$];
  int          m_tail;
  logic [2:0]  exp_ctag;
  logic [3:0]  exp_creg;
  logic [15:0] exp_cval;
  logic [3:0]  exp_cop;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_tail   = 0;
    exp_ctag = '0;
    exp_creg = '0;
    exp_cval = '0;
    exp_cop  = '0;
  endtask

  // One clock cycle: drive inputs, check pre-edge combinational outputs,
  // advance the model, then check registered outputs after the edge.
  task automatic cycle(input bit av, input logic [3:0] op, input logic [3:0] dest,
                       input bit wv, input logic [2:0] wtag, input logic [15:0] wval);
    bit   ready, do_alloc, do_commit, legal, exp_cv;
    int   idx;
    ent_t e;
    alloc_valid  = av;
    alloc_opcode = op;
    alloc_dest   = dest;
    wb_valid     = wv;
    wb_tag       = wtag;
    wb_value     = wval;
    #1;
    ready = (q.size() < DEPTH);
    check("alloc_ready", alloc_ready, ready);
    check("alloc_tag", alloc_tag, m_tail);
    check("count", count, q.size());
    check("empty", empty, q.size() == 0);
    check("full", full, q.size() == DEPTH);

    do_alloc  = av && ready;
    do_commit = (q.size() > 0) && q[0].done;
    idx = -1;
    for (int i = 0; i < q.size(); i++) if (q[i].tag == wtag) idx = i;
    legal = wv && (idx >= 0) && !q[idx].done;
    if (legal) begin
      e = q[idx];
      e.done = 1'b1;
      e.val  = wval;
      q[idx] = e;
    end
    exp_cv = do_commit;
    if (do_commit) begin
      e = q.pop_front();
      exp_ctag = e.tag;
      exp_creg = e.dest;
      exp_cval = e.val;
      exp_cop  = e.op;
    end
    if (do_alloc) begin
      e.tag = 3'(m_tail); e.op = op; e.dest = dest; e.done = 1'b0; e.val = '0;
      q.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end

    @(posedge clk);
    #1;
    check("commit_valid", commit_valid, exp_cv);
    check("commit_tag", commit_tag, exp_ctag);
    check("commit_reg", commit_reg, exp_creg);
    check("commit_value", commit_value, exp_cval);
    check("commit_opcode", commit_opcode, exp_cop);
    check("wb_err", wb_err, wv && !legal);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 4'h0, 4'h0, 0, 3'd0, 16'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_commit_valid", commit_valid, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Write back every outstanding entry (oldest not-done first) until empty.
  task automatic drain();
    int t;
    for (int k = 0; k < 40 && q.size() > 0; k++) begin
      t = -1;
      for (int i = q.size() - 1; i >= 0; i--) if (!q[i].done) t = q[i].tag;
      if (t >= 0) cycle(0, 4'h0, 4'h0, 1, 3'(t), 16'($urandom));
      else        idle(1);
    end
    check("drain_empty", q.size() == 0 && empty, 1);
  endtask

  initial begin
    logic [2:0] rtag;
    int         pick;
    rst = 1'b1;
    alloc_valid = 0; alloc_opcode = 0; alloc_dest = 0;
    wb_valid = 0; wb_tag = 0; wb_value = 0;
    model_clear();
    #2;
    check("init_tag", alloc_tag, 0);
    check("init_full", full, 0);
    check("init_ready", alloc_ready, 1);
    check("init_wb_err", wb_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset.
    idle(3);

    // Single instruction: alloc, writeback, commit.
    cycle(1, 4'h0, 4'h3, 0, 3'd0, 16'h0);
    cycle(0, 4'h0, 4'h0, 1, 3'd0, 16'h00A5);
    cycle(0, 4'h0, 4'h0, 0, 3'd0, 16'h0);
    check("single_value", commit_value, 16'h00A5);
    idle(1);

    // Out-of-order writebacks retire in order.
    do_reset();
    cycle(1, 4'h1, 4'h1, 0, 3'd0, 16'h0);
    cycle(1, 4'h2, 4'h2, 0, 3'd0, 16'h0);
    cycle(1, 4'h3, 4'h4, 0, 3'd0, 16'h0);
    cycle(0, 4'h0, 4'h0, 1, 3'd2, 16'h2222);
    cycle(0, 4'h0, 4'h0, 1, 3'd1, 16'h1111);
    cycle(0, 4'h0, 4'h0, 1, 3'd0, 16'h0BAD);
    idle(4);

    // Fill, overflow attempt, commit edge does not admit, wrap to tag 0.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, 4'(i), 4'(i + 8), 0, 3'd0, 16'h0);
    cycle(1, 4'hF, 4'hF, 0, 3'd0, 16'h0);
    cycle(0, 4'h0, 4'h0, 1, 3'd0, 16'hC0DE);
    cycle(1, 4'hE, 4'hE, 0, 3'd0, 16'h0);
    cycle(1, 4'hD, 4'hD, 0, 3'd0, 16'h0);
    drain();

    // Illegal writebacks: not busy, then already done.
    do_reset();
    cycle(0, 4'h0, 4'h0, 1, 3'd5, 16'hDEAD);
    cycle(1, 4'h4, 4'h6, 0, 3'd0, 16'h0);
    cycle(1, 4'h5, 4'h7, 0, 3'd0, 16'h0);
    cycle(0, 4'h0, 4'h0, 1, 3'd1, 16'h1234);
    cycle(0, 4'h0, 4'h0, 1, 3'd1, 16'hFFFF);
    cycle(0, 4'h0, 4'h0, 1, 3'd0, 16'h5678);
    idle(3);
    check("kept_value", commit_value, 16'h1234);

    // Writeback to the tag allocated on the same edge is illegal.
    cycle(1, 4'h6, 4'h2, 1, 3'(m_tail), 16'h7777);
    drain();

    // Asynchronous reset with entries in flight and a commit pulse active.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 4'(i), 4'(i), 0, 3'd0, 16'h0);
    cycle(0, 4'h0, 4'h0, 1, 3'd0, 16'h4444);
    idle(1);
    check("pre_rst_commit", commit_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_count", count, 0);
    check("async_commit_valid", commit_valid, 0);
    check("async_empty", empty, 1);
    check("async_tag", alloc_tag, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1, 4'h9, 4'h9, 0, 3'd0, 16'h0);
    drain();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      rtag = 3'($urandom_range(0, DEPTH - 1));
      pick = 0;
      for (int i = 0; i < q.size(); i++) if (!q[i].done) pick++;
      if (pick > 0 && $urandom_range(0, 4) != 0) begin
        pick = $urandom_range(0, pick - 1);
        for (int i = 0; i < q.size(); i++) begin
          if (!q[i].done) begin
            if (pick == 0) rtag = q[i].tag;
            pick--;
          end
        end
      end
      cycle($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
            $urandom_range(0, 9) < 7, rtag, 16'($urandom));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
